multicycle_control: RTL

Main sequencing FSM for the multi-cycle RISC core. It walks each instruction through fetch, decode, execute, memory and write-back, waits on the shared memory's ready handshake, and drives every datapath enable. It also drives the 2-bit `ALUOp` into `ALUControl`, which turns it into the 3-bit ALU code. It keeps a retired-instruction counter and parks the core on HALT or on an illegal opcode.

---
 rtl/cpu_ctrl_pkg.sv | 58 +++++
 rtl/opcode_decode.sv | 24 ++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle core sequencer: state codes, opcodes,
// opcode classes and datapath select encodings.
package cpu_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_EXEC_R   = 4'd3;
  localparam state_t S_EXEC_I   = 4'd4;
  localparam state_t S_MEM_ADDR = 4'd5;
  localparam state_t S_MEM_RD   = 4'd6;
  localparam state_t S_MEM_WR   = 4'd7;
  localparam state_t S_WB_R     = 4'd8;
  localparam state_t S_WB_I     = 4'd9;
  localparam state_t S_WB_MEM   = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_JUMP     = 4'd12;
  localparam state_t S_HALT     = 4'd13;
  localparam state_t S_TRAP     = 4'd14;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_ADDI,
    CLS_ANDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_JMP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_AND   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/opcode_decode.sv
// Combinational map from the 4-bit instruction opcode to its execution class.
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] Opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (Opcode)
      OP_R:    op_class = CLS_R;
      OP_ADDI: op_class = CLS_ADDI;
      OP_ANDI: op_class = CLS_ANDI;
      OP_LW:   op_class = CLS_LW;
      OP_SW:   op_class = CLS_SW;
      OP_BEQ:  op_class = CLS_BEQ;
      OP_JMP:  op_class = CLS_JMP;
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM of the multi-cycle core: steps instructions through their
// phases, drives datapath enables and counts retired instructions.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       Opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t    state_q, state_d;
  op_class_e dec_class;
  op_class_e cls_q;
  logic      retire;

  // The branch decision is made in the datapath by qualifying PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  opcode_decode u_opcode_decode (
    .Opcode   (Opcode),
    .op_class (dec_class)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (dec_class)
          CLS_R:              state_d = S_EXEC_R;
          CLS_ADDI, CLS_ANDI: state_d = S_EXEC_I;
          CLS_LW, CLS_SW:     state_d = S_MEM_ADDR;
          CLS_BEQ:            state_d = S_BRANCH;
          CLS_JMP:            state_d = S_JUMP;
          CLS_HALT:           state_d = S_HALT;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (cls_q == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cls_q       <= CLS_R;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= dec_class;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALUOP_RTYPE;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_ONE;
        ALUOp   = ALUOP_ADD;
        // IR and PC load only on the completing cycle of the fetch.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BOFF;
        ALUOp   = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_RTYPE;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = (cls_q == CLS_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_WB_I:   RegWrite = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_HALT:  halted  = 1'b1;
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
